wr_push_ctrl: RTL and testbench

WR_PUSH_CTRL -- requirements
Module: wr_push_ctrl

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/wr_push_ctrl_if.sv | 41 ++++
 rtl/skid_buf2.sv | 73 +++++++
 rtl/wr_push_ctrl.sv | 88 ++++++++
 tb/tb_wr_push_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults and types for the write-side push controller.
//               Holds the data/counter width defaults and the occupancy type
//               of the two-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    // Occupancy of the two-entry buffer; the encoding equals the word count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/wr_push_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wr_push_ctrl_if
// Description : Upstream valid/ready handshake plus async FIFO write port.
//               'slave' is the controller side, 'master' the environment
//               (upstream producer and FIFO full flag).
// Revision    : 1.0 - initial release
// ============================================================================
interface wr_push_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              push;
    logic [DATA_W-1:0] wdata;
    logic              full;

    modport slave (
        input  in_valid,
        input  in_data,
        input  full,
        output in_ready,
        output push,
        output wdata
    );

    modport master (
        output in_valid,
        output in_data,
        output full,
        input  in_ready,
        input  push,
        input  wdata
    );

endinterface : wr_push_ctrl_if
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
// Module      : skid_buf2
// Description : Two-entry in-order buffer. Words are written at the tail on
//               i_accept and retired from the head on i_pop. Exposes the head
//               word, the current occupancy and the next-cycle occupancy.
//               The caller must never pop when empty nor accept when full.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic              wclk,
    input  wire logic              reset_w,
    input  wire logic              i_accept,
    input  wire logic              i_pop,
    input  wire logic [DATA_W-1:0] i_din,
    output      logic [DATA_W-1:0] o_head,
    output      occ_t              o_occ,
    output      occ_t              o_occ_next
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_head_ptr;
    logic              r_tail_ptr;
    occ_t              r_occ;
    occ_t              w_occ_next;

    // Next occupancy = occ + accept - pop; accept+pop together leaves it unchanged.
    always_comb begin
        w_occ_next = r_occ;
        if (i_accept && !i_pop) begin
            w_occ_next = (r_occ == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
        end else if (!i_accept && i_pop) begin
            w_occ_next = (r_occ == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
        end
    end

    // Storage: accepted word lands in the tail slot; reset clears both slots.
    always_ff @(posedge wclk or posedge reset_w) begin
        if (reset_w) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (i_accept) begin
            r_mem[r_tail_ptr] <= i_din;
        end
    end

    // Pointers and occupancy advance together so head/tail stay consistent.
    always_ff @(posedge wclk or posedge reset_w) begin
        if (reset_w) begin
            r_head_ptr <= 1'b0;
            r_tail_ptr <= 1'b0;
            r_occ      <= OCC_EMPTY;
        end else begin
            if (i_accept) begin
                r_tail_ptr <= ~r_tail_ptr;
            end
            if (i_pop) begin
                r_head_ptr <= ~r_head_ptr;
            end
            r_occ <= w_occ_next;
        end
    end

    assign o_head     = r_mem[r_head_ptr];
    assign o_occ      = r_occ;
    assign o_occ_next = w_occ_next;

endmodule : skid_buf2
`default_nettype wire

// File: rtl/wr_push_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wr_push_ctrl
// Description : Write-side push controller for an async FIFO. Buffers up to
//               two upstream words, pushes the head whenever the FIFO is not
//               full, registers in_ready from next-cycle occupancy and keeps
//               push (wrapping) and full-stall (saturating) statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_push_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  wire logic             wclk,
    input  wire logic             reset_w,
    wr_push_ctrl_if.slave         bus,
    output      logic [CNT_W-1:0] push_cnt,
    output      logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic              r_in_ready;
    logic [CNT_W-1:0]  r_push_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_accept;
    logic              w_push;
    logic              w_stall;
    logic [DATA_W-1:0] w_head;
    occ_t              w_occ;
    occ_t              w_occ_next;

    skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .wclk       (wclk),
        .reset_w    (reset_w),
        .i_accept   (w_accept),
        .i_pop      (w_push),
        .i_din      (bus.in_data),
        .o_head     (w_head),
        .o_occ      (w_occ),
        .o_occ_next (w_occ_next)
    );

    // Push gating is purely combinational on occupancy and full, so a full
    // flag or an async reset blocks the strobe within the same cycle.
    always_comb begin
        w_accept = bus.in_valid && r_in_ready;
        w_push   = (w_occ != OCC_EMPTY) && !bus.full;
        w_stall  = (w_occ != OCC_EMPTY) && bus.full;
    end

    // in_ready registered from next occupancy: never offered when the buffer
    // will hold two words, so an accept can never overflow.
    always_ff @(posedge wclk or posedge reset_w) begin
        if (reset_w) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_occ_next != OCC_TWO);
        end
    end

    // Statistics: pushes wrap, stall cycles saturate at all-ones.
    always_ff @(posedge wclk or posedge reset_w) begin
        if (reset_w) begin
            r_push_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                r_push_cnt <= r_push_cnt + c_cnt_one;
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.push     = w_push;
    assign bus.wdata    = w_head;
    assign push_cnt     = r_push_cnt;
    assign stall_cnt    = r_stall_cnt;

endmodule : wr_push_ctrl
`default_nettype wire

// File: tb/tb_wr_push_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_push_ctrl
// Description : Self-checking bench for wr_push_ctrl: per-cycle vector tables
//               for streaming and backpressure, a scoreboard queue checking
//               push order, and hand sequences for reset and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_push_ctrl;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       full;
        logic       exp_push;
        logic       exp_ready;
        logic [7:0] exp_wdata;
    } vec_t;

    logic        wclk = 1'b0;
    logic        reset_w;
    logic [15:0] push_cnt;
    logic [15:0] stall_cnt;
    logic [3:0]  push_cnt4;
    logic [3:0]  stall_cnt4;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_push_seen = 0;
    logic [7:0]  sb_q [$];

    vec_t        stream_v [10];
    vec_t        bp_v     [8];

    always #5 wclk = ~wclk;

    wr_push_ctrl_if #(.DATA_W(8)) u_if  ();
    wr_push_ctrl_if #(.DATA_W(8)) u_if4 ();

    wr_push_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
        .wclk      (wclk),
        .reset_w   (reset_w),
        .bus       (u_if),
        .push_cnt  (push_cnt),
        .stall_cnt (stall_cnt)
    );

    wr_push_ctrl #(.DATA_W(8), .CNT_W(4)) dut4 (
        .wclk      (wclk),
        .reset_w   (reset_w),
        .bus       (u_if4),
        .push_cnt  (push_cnt4),
        .stall_cnt (stall_cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    // Drive one vector, compare at the falling edge, return after next edge.
    task automatic run_vec(input vec_t v, input string tag);
        u_if.in_valid = v.valid;
        u_if.in_data  = v.data;
        u_if.full     = v.full;
        @(negedge wclk);
        check({tag, "_push"},  32'(u_if.push),     32'(v.exp_push));
        check({tag, "_ready"}, 32'(u_if.in_ready), 32'(v.exp_ready));
        if (v.exp_push) begin
            check({tag, "_wdata"}, 32'(u_if.wdata), 32'(v.exp_wdata));
        end
        step();
    endtask

    // Scoreboard: accepted words queued, every push must retire the oldest.
    always @(negedge wclk) begin
        if (reset_w) begin
            sb_q.delete();
        end else begin
            if (u_if.push) begin
                n_push_seen++;
                check("push_while_full", 32'(u_if.full), 32'(0));
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'(1));
                if (sb_q.size() != 0) begin
                    check("wdata_order", 32'(u_if.wdata), 32'(sb_q.pop_front()));
                end
            end
            if (u_if.in_valid && u_if.in_ready) begin
                sb_q.push_back(u_if.in_data);
            end
            check("occ_range", 32'(sb_q.size() <= 2), 32'(1));
        end
    end

    initial begin
        // Streaming 0x01..0x08 with full=0: one-cycle latency, one word/cycle.
        for (int i = 0; i < 10; i++) begin
            stream_v[i].valid     = (i < 8);
            stream_v[i].data      = (i < 8) ? 8'(i + 1) : 8'h00;
            stream_v[i].full      = 1'b0;
            stream_v[i].exp_push  = (i >= 1) && (i <= 8);
            stream_v[i].exp_ready = 1'b1;
            stream_v[i].exp_wdata = 8'(i);
        end
        // Backpressure then release: A0/A1 buffered, A2 held, drained in order.
        bp_v[0] = '{1'b1, 8'hA0, 1'b1, 1'b0, 1'b1, 8'h00};
        bp_v[1] = '{1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 8'h00};
        bp_v[2] = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 8'h00};
        bp_v[3] = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 8'h00};
        bp_v[4] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'hA0};
        bp_v[5] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1};
        bp_v[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA2};
        bp_v[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};

        u_if.in_valid  = 1'b0;
        u_if.in_data   = 8'h00;
        u_if.full      = 1'b0;
        u_if4.in_valid = 1'b0;
        u_if4.in_data  = 8'h00;
        u_if4.full     = 1'b1;
        reset_w        = 1'b1;

        // Reset: three cycles held, outputs quiet, then in_ready one edge later.
        repeat (3) begin
            @(negedge wclk);
            check("rst_ready", 32'(u_if.in_ready), 32'(0));
        end
        check("rst_push",      32'(u_if.push),  32'(0));
        check("rst_push_cnt",  32'(push_cnt),   32'(0));
        check("rst_stall_cnt", 32'(stall_cnt),  32'(0));
        check("rst_wdata",     32'(u_if.wdata), 32'(0));
        step();
        reset_w = 1'b0;
        @(negedge wclk);
        check("rel_ready_before_edge", 32'(u_if.in_ready), 32'(0));
        step();
        check("rel_ready_after_edge", 32'(u_if.in_ready), 32'(1));

        for (int i = 0; i < 10; i++) run_vec(stream_v[i], "stream");
        check("stream_push_cnt",  32'(push_cnt),  32'(8));
        check("stream_stall_cnt", 32'(stall_cnt), 32'(0));

        for (int i = 0; i < 8; i++) run_vec(bp_v[i], "bp");
        check("bp_push_cnt",  32'(push_cnt),    32'(11));
        check("bp_stall_cnt", 32'(stall_cnt),   32'(3));
        check("bp_drained",   32'(sb_q.size()), 32'(0));

        // Mid-operation reset with two words buffered.
        u_if.full = 1'b1; u_if.in_valid = 1'b1; u_if.in_data = 8'hB0; step();
        u_if.in_data = 8'hB1; step();
        u_if.in_valid = 1'b0; step();
        u_if.full = 1'b0;
        #1;
        check("mid_push_before_rst", 32'(u_if.push), 32'(1));
        reset_w = 1'b1;
        #1;
        check("mid_push_async_drop", 32'(u_if.push),     32'(0));
        check("mid_ready_async",     32'(u_if.in_ready), 32'(0));
        @(posedge wclk);
        @(posedge wclk);
        #1;
        reset_w = 1'b0;
        begin
            int seen0;
            seen0 = n_push_seen;
            repeat (4) step();
            check("mid_no_stale_push", 32'(n_push_seen), 32'(seen0));
        end
        check("mid_push_cnt",  32'(push_cnt),  32'(0));
        check("mid_stall_cnt", 32'(stall_cnt), 32'(0));

        // Traffic resumes cleanly after the mid-operation reset.
        for (int i = 0; i < 3; i++) begin
            u_if.in_valid = 1'b1;
            u_if.in_data  = 8'(8'hC0 + i);
            step();
        end
        u_if.in_valid = 1'b0;
        repeat (3) step();
        check("resume_push_cnt", 32'(push_cnt),    32'(3));
        check("resume_drained",  32'(sb_q.size()), 32'(0));

        // Four-bit stall counter saturates with a word parked behind full.
        u_if4.in_valid = 1'b1;
        u_if4.in_data  = 8'h55;
        step();
        u_if4.in_valid = 1'b0;
        repeat (20) begin
            step();
            check("sat_no_push", 32'(u_if4.push), 32'(0));
        end
        check("sat_stall_cnt4", 32'(stall_cnt4), 32'(15));
        u_if4.full = 1'b0;
        #1;
        check("sat_push_release", 32'(u_if4.push),  32'(1));
        check("sat_wdata",        32'(u_if4.wdata), 32'(8'h55));
        step();
        check("sat_push_cnt4",  32'(push_cnt4),  32'(1));
        check("sat_stall_hold", 32'(stall_cnt4), 32'(15));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_wr_push_ctrl
`default_nettype wire
